// File: rtl/lsu_bus_bridge.sv
// lsu_bus_bridge: turns the single-cycle datapath's load/store port into a
// valid/ready bus request plus single-beat response, holding Stall until the
// access completes and returning the raw aligned bus word.
// Optional build macro: LSU_TIMEOUT_EN (aborts WAIT after RSP_TIMEOUT cycles).
module lsu_bus_bridge #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned RSP_TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        Funct3,
    input  logic [31:0]       Mem_WrAddr,
    input  logic [31:0]       Mem_WrData,
    output logic [31:0]       ReadData,
    output logic              Stall,
    output logic              MisalignErr,
    output logic              BusErr,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    output logic [3:0]        bus_wstrb,
    input  logic              bus_rsp_valid,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_rsp_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic              bus_we_q;
    logic [31:0]       bus_wdata_q;
    logic [3:0]        bus_wstrb_q;
    logic              bus_req_valid_q;
    logic [31:0]       ReadData_q;
    logic              MisalignErr_q;
    logic              BusErr_q;

    logic              req_any;
    logic [1:0]        size;
    logic              misalign_d;
    logic [3:0]        strb_d;
    logic [ADDR_W-1:0] addr_ext;
    logic [ADDR_W-1:0] addr_d;

    // Funct3[2] only selects load sign extension, which happens downstream.
    logic unused_funct3;
    assign unused_funct3 = Funct3[2];

    assign req_any = MemRead | MemWrite;
    assign size    = Funct3[1:0];

    // Fit the 32-bit core address to the bus width (zero-extend or truncate).
    if (ADDR_W > 32) begin : g_addr_wide
        assign addr_ext = {{(ADDR_W-32){1'b0}}, Mem_WrAddr};
    end else if (ADDR_W == 32) begin : g_addr_same
        assign addr_ext = Mem_WrAddr;
    end else begin : g_addr_narrow
        logic [31-ADDR_W:0] unused_addr_hi;
        assign unused_addr_hi = Mem_WrAddr[31:ADDR_W];
        assign addr_ext       = Mem_WrAddr[ADDR_W-1:0];
    end

    assign addr_d = {addr_ext[ADDR_W-1:2], 2'b00};

    // Alignment check and byte-lane enables from size and low address bits.
    always_comb begin
        misalign_d = 1'b0;
        strb_d     = 4'b1111;
        case (size)
            2'b00: begin
                misalign_d = 1'b0;
                strb_d     = 4'b0001 << Mem_WrAddr[1:0];
            end
            2'b01: begin
                misalign_d = Mem_WrAddr[0];
                strb_d     = Mem_WrAddr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                misalign_d = |Mem_WrAddr[1:0];
                strb_d     = 4'b1111;
            end
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned TMO_W = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT + 1) : 1;
    logic [TMO_W-1:0] tmo_cnt_q;
`endif

    // Access sequencer: registers the request, drives the bus, collects the response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            bus_addr_q      <= '0;
            bus_we_q        <= 1'b0;
            bus_wdata_q     <= '0;
            bus_wstrb_q     <= '0;
            bus_req_valid_q <= 1'b0;
            ReadData_q      <= '0;
            MisalignErr_q   <= 1'b0;
            BusErr_q        <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            tmo_cnt_q       <= '0;
`endif
        end else begin
            // Error flags are single-cycle pulses, set only on entry to DONE.
            MisalignErr_q <= 1'b0;
            BusErr_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_any) begin
                        bus_addr_q  <= addr_d;
                        bus_we_q    <= MemWrite;
                        bus_wdata_q <= Mem_WrData;
                        bus_wstrb_q <= MemWrite ? strb_d : 4'b0000;
                        if (misalign_d) begin
                            state_q       <= S_DONE;
                            MisalignErr_q <= 1'b1;
                            ReadData_q    <= '0;
                        end else begin
                            state_q         <= S_REQ;
                            bus_req_valid_q <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (bus_req_ready) begin
                        state_q         <= S_WAIT;
                        bus_req_valid_q <= 1'b0;
`ifdef LSU_TIMEOUT_EN
                        tmo_cnt_q       <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    if (bus_rsp_valid) begin
                        state_q <= S_DONE;
                        if (bus_rsp_err) begin
                            BusErr_q   <= 1'b1;
                            ReadData_q <= '0;
                        end else if (!bus_we_q) begin
                            ReadData_q <= bus_rdata;
                        end
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (tmo_cnt_q == TMO_W'(RSP_TIMEOUT - 1)) begin
                        state_q    <= S_DONE;
                        BusErr_q   <= 1'b1;
                        ReadData_q <= '0;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                    end
`endif
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Stall rises combinationally on detection so the PC freezes the same cycle.
    assign Stall = reset & (((state_q == S_IDLE) & req_any) |
                            (state_q == S_REQ) | (state_q == S_WAIT));

    assign bus_req_valid = bus_req_valid_q;
    assign bus_we        = bus_we_q;
    assign bus_addr      = bus_addr_q;
    assign bus_wdata     = bus_wdata_q;
    assign bus_wstrb     = bus_wstrb_q;
    assign ReadData      = ReadData_q;
    assign MisalignErr   = MisalignErr_q;
    assign BusErr        = BusErr_q;

endmodule
